mem_access_stage: RTL and testbench

Memory stage of the ARM pipeline: accepts the executed instruction from EX, performs any load/store on a single-outstanding req/ack data-memory port, and registers the result into the MEM/WB word that drives the register file write port (`wb_en`, `dest_wb`, `result_wb`). Stalls upstream while an access is in flight and aborts hung accesses with a watchdog.

---
 rtl/arm_pipe_pkg.sv | 15 +
 rtl/mem_wb_reg.sv | 32 +++
 rtl/mem_access_stage.sv | 157 +++++++++++++++
 tb/tb_mem_access_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline definitions: default datapath widths, the memory-stage
// state encoding and the width of the memory-stage watchdog counter.
package arm_pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;
  // Watchdog wide enough for TIMEOUT values up to 255.
  localparam int unsigned WD_W   = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage : arm_pipe_pkg

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: {wb_en, dest, data}, reloaded every cycle.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   wb_en_next, dest_next, data_next  next MEM/WB word
//   wb_en, dest, data                 registered MEM/WB word (register file write port)
module mem_wb_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en_next,
  input  logic [REG_AW-1:0] dest_next,
  input  logic [DATA_W-1:0] data_next,
  output logic              wb_en,
  output logic [REG_AW-1:0] dest,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en <= 1'b0;
      dest  <= '0;
      data  <= '0;
    end else begin
      wb_en <= wb_en_next;
      dest  <= dest_next;
      data  <= data_next;
    end
  end

endmodule : mem_wb_reg

// File: rtl/mem_access_stage.sv
// ARM pipeline memory stage: takes the executed instruction from EX, runs any
// load/store on a single-outstanding req/ack data-memory port, and registers
// the result into the MEM/WB word. Hung accesses are aborted by a watchdog.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   ex_*                        instruction presented by EX
//   stall                       combinational hold request to EX/upstream
//   mem_req/we/addr/wdata       registered data-memory request
//   mem_ack, mem_rdata          memory completion and read data
//   mem_err                     one-cycle pulse when the watchdog aborts
//   wb_en, dest_wb, result_wb   MEM/WB register file write port
module mem_access_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_val,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_wb_en,
  input  logic              ex_mem_r,
  input  logic              ex_mem_w,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic              wb_en,
  output logic [REG_AW-1:0] dest_wb,
  output logic [DATA_W-1:0] result_wb
);

  import arm_pipe_pkg::*;

  state_t            state, state_n;
  logic [WD_W-1:0]   wd, wd_n;
  logic              req_n, we_n, err_n;
  logic [DATA_W-1:0] addr_n, wdata_n;
  logic              lat_wb, lat_wb_n;
  logic [REG_AW-1:0] lat_dest, lat_dest_n;
  logic              stall_c;
  logic              memop;
  logic              wb_en_d;
  logic [REG_AW-1:0] dest_d;
  logic [DATA_W-1:0] data_d;

  assign memop = ex_valid & (ex_mem_r | ex_mem_w);

  // Stall is suppressed while reset is asserted so upstream never freezes in reset.
  assign stall = stall_c & rst_n;

  // State, watchdog and memory port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wd        <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_wb    <= 1'b0;
      lat_dest  <= '0;
    end else begin
      state     <= state_n;
      wd        <= wd_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_err   <= err_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      lat_wb    <= lat_wb_n;
      lat_dest  <= lat_dest_n;
    end
  end

  // Next-state, stall and next MEM/WB word.
  always_comb begin
    state_n    = state;
    wd_n       = wd;
    req_n      = mem_req;
    we_n       = mem_we;
    err_n      = 1'b0;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    lat_wb_n   = lat_wb;
    lat_dest_n = lat_dest;
    stall_c    = 1'b0;
    wb_en_d    = 1'b0;
    dest_d     = ex_dest;
    data_d     = ex_alu_result;

    unique case (state)
      IDLE: begin
        if (memop) begin
          // Load wins when both load and store are flagged.
          stall_c    = 1'b1;
          req_n      = 1'b1;
          we_n       = ~ex_mem_r;
          addr_n     = ex_alu_result;
          wdata_n    = ex_store_val;
          lat_wb_n   = ex_valid & ex_wb_en;
          lat_dest_n = ex_dest;
          wd_n       = '0;
          state_n    = ACCESS;
        end else begin
          wb_en_d = ex_valid & ex_wb_en;
        end
      end

      ACCESS: begin
        dest_d = lat_dest;
        data_d = mem_addr;
        if (mem_ack) begin
          // Ack on the final watchdog cycle still completes the access.
          req_n   = 1'b0;
          state_n = IDLE;
          if (!mem_we) begin
            wb_en_d = lat_wb;
            data_d  = mem_rdata;
          end
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          // Abort: drop the instruction and let EX advance this cycle.
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          stall_c = 1'b1;
          wd_n    = wd + WD_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_mem_wb_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_en_next (wb_en_d),
    .dest_next  (dest_d),
    .data_next  (data_d),
    .wb_en      (wb_en),
    .dest       (dest_wb),
    .data       (result_wb)
  );

endmodule : mem_access_stage

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage: a driver issues
// instructions and predicts register writes / memory accesses at the
// instruction level, a memory responder answers requests, and a monitor
// checks every register write against the expected queue.
module tb_mem_access_stage;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned TO    = 4;
  localparam int          NOACK = 99;

  logic          clk;
  logic          rst_n;
  logic          ex_valid;
  logic [DW-1:0] ex_alu_result;
  logic [DW-1:0] ex_store_val;
  logic [AW-1:0] ex_dest;
  logic          ex_wb_en;
  logic          ex_mem_r;
  logic          ex_mem_w;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;
  logic          wb_en;
  logic [AW-1:0] dest_wb;
  logic [DW-1:0] result_wb;

  mem_access_stage #(
    .DATA_W  (DW),
    .REG_AW  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_val  (ex_store_val),
    .ex_dest       (ex_dest),
    .ex_wb_en      (ex_wb_en),
    .ex_mem_r      (ex_mem_r),
    .ex_mem_w      (ex_mem_w),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .mem_err       (mem_err),
    .wb_en         (wb_en),
    .dest_wb       (dest_wb),
    .result_wb     (result_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [DW-1:0] alu;
    logic [DW-1:0] sval;
    logic [AW-1:0] dest;
    logic          wb;
    logic          r;
    logic          w;
    int            delay;
    logic [DW-1:0] rdata;
  } instr_t;

  typedef struct {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    logic [DW-1:0] rdata;
  } acc_t;

  logic [AW+DW-1:0] wr_q[$];
  acc_t             acc_q[$];
  int               compared   = 0;
  int               mismatched = 0;
  int               err_exp    = 0;
  int               err_seen   = 0;
  logic             quiet      = 1'b1;
  logic             force_ack  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] sv,
                                input logic [AW-1:0] d, input logic wb, input logic r,
                                input logic w, input int dly, input logic [DW-1:0] rd);
    instr_t t;
    t.valid = v; t.alu = alu; t.sval = sv; t.dest = d; t.wb = wb;
    t.r = r; t.w = w; t.delay = dly; t.rdata = rd;
    return t;
  endfunction

  // Present one instruction, predict its outcome, wait until EX is released.
  task automatic issue(input instr_t t);
    acc_t a;
    int   exp_stall;
    int   nstall;
    if (t.valid && (t.r || t.w)) begin
      a.we = ~t.r; a.addr = t.alu; a.wdata = t.sval; a.delay = t.delay; a.rdata = t.rdata;
      acc_q.push_back(a);
      if (t.delay == NOACK) begin
        err_exp++;
        exp_stall = TO;
      end else begin
        if (t.r && t.wb) wr_q.push_back({t.dest, t.rdata});
        exp_stall = t.delay + 1;
      end
    end else begin
      if (t.valid && t.wb) wr_q.push_back({t.dest, t.alu});
      exp_stall = 0;
    end
    ex_valid = t.valid; ex_alu_result = t.alu; ex_store_val = t.sval; ex_dest = t.dest;
    ex_wb_en = t.wb; ex_mem_r = t.r; ex_mem_w = t.w;
    nstall = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      nstall++;
      if (nstall > 40) begin
        check("stall_timeout", 64'(nstall), 64'(exp_stall));
        break;
      end
    end
    if (nstall <= 40) check("stall_cycles", 64'(nstall), 64'(exp_stall));
    @(posedge clk); #1;
  endtask

  // Memory responder: checks each request and acks after the planned delay.
  initial begin : responder
    acc_t cur;
    logic serving;
    int   cyc;
    serving = 1'b0; cyc = 0;
    cur.we = 1'b0; cur.addr = '0; cur.wdata = '0; cur.delay = 0; cur.rdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!rst_n || quiet) begin
        serving = 1'b0;
        mem_ack = force_ack;
        mem_rdata = $urandom;
      end else begin
        if (mem_req && !serving) begin
          if (acc_q.size() == 0) begin
            check("unexpected_req", 64'(mem_req), 64'(0));
          end else begin
            cur = acc_q.pop_front();
            check("mem_we", 64'(mem_we), 64'(cur.we));
            check("mem_addr", 64'(mem_addr), 64'(cur.addr));
            check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
            serving = 1'b1;
            cyc = 0;
          end
        end else if (!mem_req && serving) begin
          check("abort_expected", 64'(cur.delay), 64'(NOACK));
          check("abort_wait_cycles", 64'(cyc), 64'(TO));
          serving = 1'b0;
        end
        if (serving) begin
          if (mem_addr !== cur.addr) check("addr_stable", 64'(mem_addr), 64'(cur.addr));
          if (cyc == cur.delay) begin
            mem_ack = 1'b1;
            mem_rdata = cur.rdata;
            serving = 1'b0;
          end else begin
            mem_rdata = $urandom;
          end
          cyc++;
        end else begin
          // Spurious acks while no access is outstanding must be ignored.
          mem_ack = ($urandom_range(0, 3) == 0);
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: every register write must match the head of the expected queue.
  initial begin : monitor
    logic             prev_err;
    logic [AW+DW-1:0] e;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && !quiet) begin
        if (wb_en) begin
          if (wr_q.size() == 0) begin
            check("unexpected_write", {28'd0, dest_wb, result_wb}, 64'(0));
          end else begin
            e = wr_q.pop_front();
            check("write_word", {28'd0, dest_wb, result_wb}, {28'd0, e});
          end
        end
        if (mem_err) begin
          err_seen++;
          if (prev_err) check("err_pulse_width", 64'(2), 64'(1));
        end
        prev_err = mem_err;
      end else begin
        prev_err = 1'b0;
      end
    end
  end

  initial begin : main
    instr_t t;
    int     k;
    int     dly;
    rst_n = 1'b0;
    ex_valid = 1'b1; ex_alu_result = 32'h1111; ex_store_val = 32'h2222; ex_dest = 4'd9;
    ex_wb_en = 1'b1; ex_mem_r = 1'b1; ex_mem_w = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_err", 64'(mem_err), 64'(0));
    check("rst_wb_en", 64'(wb_en), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_result_wb", 64'(result_wb), 64'(0));
    check("rst_dest_wb", 64'(dest_wb), 64'(0));
    ex_valid = 1'b0;
    rst_n = 1'b1;
    quiet = 1'b0;
    @(posedge clk); #1;

    // Directed sequence.
    issue(mk(1'b1, 32'h1234, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 0, 32'h0));
    issue(mk(1'b1, 32'h40, 32'h0, 4'd5, 1'b1, 1'b1, 1'b0, 3, 32'hDEADBEEF));
    issue(mk(1'b1, 32'h80, 32'h55, 4'd6, 1'b1, 1'b0, 1'b1, 0, 32'h0));
    issue(mk(1'b1, 32'h44, 32'h0, 4'd7, 1'b1, 1'b1, 1'b0, NOACK, 32'h0));
    issue(mk(1'b1, 32'h777, 32'h0, 4'd8, 1'b1, 1'b0, 1'b0, 0, 32'h0));
    issue(mk(1'b1, 32'h100, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0, 1, 32'hCAFE0001));
    issue(mk(1'b1, 32'h2468, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0, 0, 32'h0));
    issue(mk(1'b1, 32'h104, 32'hA5A5, 4'd4, 1'b1, 1'b0, 1'b1, 2, 32'h0));
    issue(mk(1'b1, 32'h108, 32'hBB, 4'd10, 1'b1, 1'b1, 1'b1, 0, 32'h13579BDF));

    // Randomized stream.
    for (int i = 0; i < 250; i++) begin
      k   = $urandom_range(0, 9);
      dly = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : NOACK;
      t = mk(1'b1, $urandom, $urandom, 4'($urandom), ($urandom_range(0, 4) != 0),
             1'b0, 1'b0, dly, $urandom);
      if (k >= 4 && k <= 5) t.r = 1'b1;
      else if (k >= 6 && k <= 7) t.w = 1'b1;
      else if (k == 8) begin t.r = 1'b1; t.w = 1'b1; end
      else if (k == 9) begin t.valid = 1'b0; t.r = 1'($urandom); t.w = 1'($urandom); end
      issue(t);
    end

    // Drain with bubbles and check nothing is left outstanding.
    for (int i = 0; i < 4; i++) issue(mk(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 32'h0));
    check("writes_left", 64'(wr_q.size()), 64'(0));
    check("accesses_left", 64'(acc_q.size()), 64'(0));
    check("err_count", 64'(err_seen), 64'(err_exp));

    // Reset in the middle of an access, then a late ack.
    quiet = 1'b1;
    ex_valid = 1'b1; ex_alu_result = 32'h99; ex_store_val = 32'h0; ex_dest = 4'd7;
    ex_wb_en = 1'b1; ex_mem_r = 1'b1; ex_mem_w = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_req_before", 64'(mem_req), 64'(1));
    check("midrst_addr_before", 64'(mem_addr), 64'(32'h99));
    rst_n = 1'b0;
    #1;
    check("midrst_req", 64'(mem_req), 64'(0));
    check("midrst_addr", 64'(mem_addr), 64'(0));
    check("midrst_stall", 64'(stall), 64'(0));
    check("midrst_wb_en", 64'(wb_en), 64'(0));
    check("midrst_result", 64'(result_wb), 64'(0));
    force_ack = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_wb_en", 64'(wb_en), 64'(0));
      check("late_ack_req", 64'(mem_req), 64'(0));
      check("late_ack_err", 64'(mem_err), 64'(0));
      check("late_ack_stall", 64'(stall), 64'(0));
    end
    @(posedge clk); #1;
    force_ack = 1'b0;
    quiet = 1'b0;
    issue(mk(1'b1, 32'h5A5A, 32'h0, 4'd11, 1'b1, 1'b0, 1'b0, 0, 32'h0));
    issue(mk(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 32'h0));
    issue(mk(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 32'h0));
    check("post_reset_writes_left", 64'(wr_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mem_access_stage
